// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
// The DUMP state exists only when SRAM_ARB_DUMP_EN is defined.
package sram_arb_pkg;

   localparam int unsigned SRAM_ADDR_W = 16;
   localparam int unsigned SRAM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2
`ifdef SRAM_ARB_DUMP_EN
      ,DUMP   = 2'd3
`endif
   } sram_arb_state_t;

   // One-hot completion vector for a transaction owner.
   function automatic logic [1:0] owner_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sram_rr_grant.sv
// Two-way round-robin grant: on a tie, the requester not served last wins.
// Unaffected by SRAM_ARB_DUMP_EN; dump priority is folded into enable.
module sram_rr_grant (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (&req_valid) grant = last_grant ? 2'b01 : 2'b10;
         else            grant = req_valid;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin access controller serialising two requesters onto a level-strobed SRAM.
// Define SRAM_ARB_DUMP_EN to add the dump request path and DUMP state.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = SRAM_ADDR_W,
   parameter int unsigned DATA_W    = SRAM_DATA_W,
   parameter int unsigned READ_WAIT = 2
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [1:0]        req_valid,
   input  logic [1:0]        req_write,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        req_ready,
   output logic [1:0]        resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              sram_read,
   output logic              sram_write,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
`ifdef SRAM_ARB_DUMP_EN
   ,
   input  logic              dump_req,
   input  logic              dump_num,
   output logic              sram_dump,
   output logic              sram_dump_num,
   output logic              dump_done
`endif
);

   localparam int unsigned CNT_W = $clog2(READ_WAIT + 1);

   sram_arb_state_t   state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rd_stb_q, rd_stb_d;
   logic              wr_stb_q, wr_stb_d;
   logic [1:0]        resp_q, resp_d;
   logic [1:0]        grant;
   logic              arb_en;

`ifdef SRAM_ARB_DUMP_EN
   logic dump_stb_q, dump_stb_d;
   logic dump_num_q, dump_num_d;
   logic dump_done_q, dump_done_d;

   assign arb_en = (state_q == IDLE) & ~dump_req;
`else
   assign arb_en = (state_q == IDLE);
`endif

   sram_rr_grant u_grant (
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .enable     (arb_en),
      .grant      (grant)
   );

   assign req_ready = grant;

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      rd_stb_d     = 1'b0;
      wr_stb_d     = 1'b0;
      resp_d       = 2'b00;
`ifdef SRAM_ARB_DUMP_EN
      dump_stb_d   = 1'b0;
      dump_num_d   = dump_num_q;
      dump_done_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef SRAM_ARB_DUMP_EN
            if (dump_req) begin
               state_d    = DUMP;
               dump_stb_d = 1'b1;
               dump_num_d = dump_num;
            end else
`endif
            if (grant != 2'b00) begin
               owner_d      = grant[1];
               last_grant_d = grant[1];
               write_d      = req_write[grant[1]];
               addr_d       = grant[1] ? req_addr1 : req_addr0;
               wdata_d      = grant[1] ? req_wdata1 : req_wdata0;
               cnt_d        = CNT_W'(READ_WAIT);
               wr_stb_d     = write_d;
               rd_stb_d     = ~write_d;
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            // Writes take one cycle; reads run until the counter reaches its last tick.
            if (write_q || (cnt_q == CNT_W'(1))) begin
               state_d = RECOVER;
               cnt_d   = '0;
               resp_d  = owner_onehot(owner_q);
               if (!write_q) rdata_d = sram_rdata;
            end else begin
               cnt_d    = cnt_q - CNT_W'(1);
               rd_stb_d = 1'b1;
            end
         end
         RECOVER: state_d = IDLE;
`ifdef SRAM_ARB_DUMP_EN
         DUMP: begin
            state_d     = RECOVER;
            dump_done_d = 1'b1;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         owner_q      <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         rd_stb_q     <= 1'b0;
         wr_stb_q     <= 1'b0;
         resp_q       <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         rd_stb_q     <= rd_stb_d;
         wr_stb_q     <= wr_stb_d;
         resp_q       <= resp_d;
      end
   end

`ifdef SRAM_ARB_DUMP_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dump_stb_q  <= 1'b0;
         dump_num_q  <= 1'b0;
         dump_done_q <= 1'b0;
      end else begin
         dump_stb_q  <= dump_stb_d;
         dump_num_q  <= dump_num_d;
         dump_done_q <= dump_done_d;
      end
   end

   assign sram_dump     = dump_stb_q;
   assign sram_dump_num = dump_num_q;
   assign dump_done     = dump_done_q;
`endif

   assign sram_read  = rd_stb_q;
   assign sram_write = wr_stb_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;
   assign resp_valid = resp_q;
   assign resp_rdata = rdata_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin access controller for the shared `testing_sram` model. Two requesters issue single-byte read/write transactions over a valid/ready handshake. The block serialises them onto the SRAM's level-strobed `read`/`write` interface, holding each strobe for the required number of cycles with a recovery cycle between accesses. It returns read data and a completion pulse to the requester that owns the transaction.

## Interface
- `ADDR_W`, 16, SRAM address width.
- `DATA_W`, 8, SRAM data width.
- `READ_WAIT`, 2, number of cycles `sram_read` is held before data is sampled; legal range ≥1.

- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  2  per-requester request valid; index i = requester i.
- `req_write`  in  2  1 = write, 0 = read; qualified by `req_valid[i]`.
- `req_addr0`, `req_addr1`  in  ADDR_W  request address.
- `req_wdata0`, `req_wdata1`  in  DATA_W  write data.
- `req_ready`  out  2  request accepted this cycle.
- `resp_valid`  out  2  one-cycle completion pulse to the owning requester.
- `resp_rdata`  out  DATA_W  read data; valid with `resp_valid` on reads and held until the next read completes.
- `sram_read`  out  1  SRAM read strobe.
- `sram_write`  out  1  SRAM write strobe.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_wdata`  out  DATA_W  SRAM write data (drives `valueIn`).
- `sram_rdata`  in  DATA_W  SRAM read data (from `valueOut`).

## Operation
- FSM states: IDLE, ACCESS, RECOVER; DUMP is added only when the configuration macro below is defined.
- IDLE behaviour:
  - Grant requester i when `req_valid[i]`; `req_ready[i]` is combinational `(state==IDLE) & grant[i]`.
  - On handshake, latch addr, wdata, write flag and owner id, then go to ACCESS.
- Round-robin arbitration:
  - A `last_grant` bit records the most recently served requester.
  - When both requesters are valid, grant the one ≠ `last_grant`; a single valid requester is always granted.
  - `last_grant` updates on handshake.
- ACCESS:
  - `sram_addr` and `sram_wdata` are driven from the latches.
  - Writes: `sram_write`=1 for exactly 1 cycle.
  - Reads: `sram_read`=1 for READ_WAIT cycles. A down-counter of width `$clog2(READ_WAIT+1)` loads READ_WAIT on handshake. `sram_rdata` is captured into `resp_rdata` on the last ACCESS cycle.
- RECOVER:
  - All strobes are 0 for 1 cycle; `resp_valid[owner]`=1.
  - Then return to IDLE.
- Reset values: all outputs 0, state IDLE, `last_grant`=1 (requester 0 wins the first tie), counter 0.
- Boundary behaviour:
  - Reset mid-transaction: strobes drop immediately; no `resp_valid` is issued; the transaction is lost.
  - `req_valid` dropping without a handshake is legal and has no effect.
  - Addresses are passed through unmodified, so 0 and 2^ADDR_W−1 are both legal.

## Timing
- Handshake in cycle T. Strobe starts at T+1.
- Write: `resp_valid` at T+2. Read: `resp_valid` at T+READ_WAIT+1.
- Next handshake is possible at the cycle after RECOVER: T+3 for a write, T+READ_WAIT+2 for a read.
- Sustained throughput under contention alternates requesters one transaction at a time.
- Strobes are never asserted in consecutive transactions without an intervening all-low cycle.

## Configuration
- `SRAM_ARB_DUMP_EN` defined: adds the following ports.
  - Inputs: `dump_req` (1) and `dump_num` (1).
  - Outputs: `sram_dump` (1), `sram_dump_num` (1) and `dump_done` (1).
- Dump arbitration: in IDLE, `dump_req` has priority over both requesters and `req_ready` stays 0.
- DUMP state:
  - `sram_dump`=1 for 1 cycle, with `sram_dump_num` = latched `dump_num`.
  - Then RECOVER, pulsing `dump_done` instead of `resp_valid`.
- Undefined: the dump ports and DUMP state are absent and the SRAM dump inputs are tied 0 at the top level.

## Structure
- Package `sram_arb_pkg`:
  - state enum `sram_arb_state_t`;
  - default width constants `SRAM_ADDR_W`=16 and `SRAM_DATA_W`=8.
- Sub-module `sram_rr_grant`: 2-way round-robin grant logic (inputs `req_valid`, `last_grant`, `enable`; output `grant[1:0]`).

## Test plan
- Req0 writes 89 @0, then reads @0 → `sram_write` is high for one cycle; on the read, `resp_valid[0]` arrives at T+3 with `resp_rdata`=89.
- Req0 writes 210 @59 while req1 writes 66 @195 in the same cycle → req0 is served first and req1 second, with one recovery cycle between them. Subsequent reads return 210 and 66.
- Both requesters issue reads continuously → grants alternate 0,1,0,1; each `resp_valid` goes only to its owner.
- Reset asserted during read ACCESS @59 → `sram_read` drops immediately; no `resp_valid` after release; the first grant after release goes to req0.
- Address 16'hFFFF write 8'hA5, then read → 8'hA5 is returned.
- With `SRAM_ARB_DUMP_EN`: `dump_req`=1 and `dump_num`=1 while req1 is valid → `sram_dump` and `sram_dump_num`=1 for one cycle, then `dump_done`; req1 is granted afterwards.
